// File: rtl/map_loader.sv
// Writer side of the terrain map BRAM: parses a framed byte stream (sync, start x/y,
// packed 2-bit cells, XOR checksum) into one cell write per cycle and validates the frame.
module map_loader #(
    parameter int          WIDTH          = 160,
    parameter int          HEIGHT         = 90,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] wr_addr,
    output logic [1:0]  wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        load_done,
    output logic        load_error,
    output logic [1:0]  error_code,
    output logic [7:0]  start_x,
    output logic [7:0]  start_y,
    output logic        map_valid
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR_X   = 3'd1;
    localparam logic [2:0] S_HDR_Y   = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_BOUNDS   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [15:0]      NUM_BYTES    = 16'(WIDTH * HEIGHT / 4);
    localparam int               CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [7:0]       data_q;
    logic [1:0]       phase;
    logic             unpacking;
    logic [15:0]      byte_cnt;
    logic [15:0]      cell_idx;
    logic [7:0]       checksum;
    logic [CNT_W-1:0] idle_cnt;

    logic       transfer;
    logic       last_cell;
    logic       last_byte;
    logic       waiting;
    logic       check_fire;
    logic       timeout_hit;
    logic [1:0] next_phase;

    // The next byte is accepted while the 4th cell of the current one is written.
    assign last_cell   = unpacking && (phase == 2'd3);
    assign last_byte   = (byte_cnt == NUM_BYTES);
    assign byte_ready  = (state != S_PAYLOAD) || !unpacking || last_cell;
    assign transfer    = byte_valid && byte_ready;
    assign busy        = (state != S_IDLE);
    assign next_phase  = phase + 2'd1;

    assign waiting     = (state == S_HDR_X) || (state == S_HDR_Y) || (state == S_CHECK) ||
                         ((state == S_PAYLOAD) && !unpacking);
    assign timeout_hit = waiting && !transfer && (idle_cnt == TIMEOUT_LAST);

    // The checksum byte may arrive in the last write cycle of the final payload byte.
    assign check_fire  = transfer && ((state == S_CHECK) ||
                         ((state == S_PAYLOAD) && last_cell && last_byte));

    // NOTE: every register, including the output registers, takes <= so all of them
    // sample pre-edge values; blocking here would make ordering inside the block matter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            data_q     <= '0;
            phase      <= '0;
            unpacking  <= 1'b0;
            byte_cnt   <= '0;
            cell_idx   <= '0;
            checksum   <= '0;
            idle_cnt   <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            error_code <= ERR_NONE;
            start_x    <= '0;
            start_y    <= '0;
            map_valid  <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            load_error <= 1'b0;
            wr_en      <= 1'b0;

            if (waiting && !transfer && !timeout_hit) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end else begin
                idle_cnt <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (transfer && byte_in == SYNC_BYTE) begin
                        state      <= S_HDR_X;
                        checksum   <= '0;
                        error_code <= ERR_NONE;
                        map_valid  <= 1'b0;
                        byte_cnt   <= '0;
                        cell_idx   <= '0;
                        unpacking  <= 1'b0;
                        phase      <= '0;
                    end
                end
                S_HDR_X: begin
                    if (transfer) begin
                        start_x  <= byte_in;
                        checksum <= checksum ^ byte_in;
                        state    <= S_HDR_Y;
                    end
                end
                S_HDR_Y: begin
                    if (transfer) begin
                        start_y  <= byte_in;
                        checksum <= checksum ^ byte_in;
                        state    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (unpacking && !last_cell) begin
                        wr_en    <= 1'b1;
                        wr_data  <= data_q[{next_phase, 1'b0} +: 2];
                        wr_addr  <= cell_idx;
                        cell_idx <= cell_idx + 16'd1;
                        phase    <= next_phase;
                    end else if (last_cell && last_byte) begin
                        unpacking <= 1'b0;
                        if (!transfer) begin
                            state <= S_CHECK;
                        end
                    end else if (transfer) begin
                        data_q    <= byte_in;
                        checksum  <= checksum ^ byte_in;
                        byte_cnt  <= byte_cnt + 16'd1;
                        unpacking <= 1'b1;
                        phase     <= '0;
                        wr_en     <= 1'b1;
                        wr_data   <= byte_in[1:0];
                        wr_addr   <= cell_idx;
                        cell_idx  <= cell_idx + 16'd1;
                    end else begin
                        unpacking <= 1'b0;
                    end
                end
                default: begin
                end
            endcase

            if (check_fire) begin
                state <= S_IDLE;
                if (int'(start_x) >= WIDTH || int'(start_y) >= HEIGHT) begin
                    error_code <= ERR_BOUNDS;
                    load_error <= 1'b1;
                end else if (byte_in != checksum) begin
                    error_code <= ERR_CHECKSUM;
                    load_error <= 1'b1;
                end else begin
                    load_done <= 1'b1;
                    map_valid <= 1'b1;
                end
            end

            if (timeout_hit) begin
                state      <= S_IDLE;
                unpacking  <= 1'b0;
                error_code <= ERR_TIMEOUT;
                load_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_map_loader.sv
// Directed bench for map_loader on an 8x2 map (4 payload bytes) with a 20-cycle timeout.
module tb_map_loader;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int TO = 20;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] wr_addr;
    logic [1:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        load_done;
    logic        load_error;
    logic [1:0]  error_code;
    logic [7:0]  start_x;
    logic [7:0]  start_y;
    logic        map_valid;

    map_loader #(
        .WIDTH(W), .HEIGHT(H), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .busy(busy), .load_done(load_done), .load_error(load_error),
        .error_code(error_code), .start_x(start_x), .start_y(start_y), .map_valid(map_valid)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          n_lead;     // garbage bytes before the sync byte
        logic [15:0] lead;       // garbage, first byte in [7:0]
        logic [7:0]  sx;
        logic [7:0]  sy;
        logic [31:0] payload;    // payload byte k in [8k+7:8k]
        logic [7:0]  csum;
        int          gap;        // idle cycles before the checksum byte
        logic        exp_done;
        logic [1:0]  exp_err;
        logic [31:0] exp_cells;  // cell i in [2i+1:2i]
    } vec_t;

    vec_t vecs [7];

    int total = 0;
    int bad   = 0;

    // Write log filled by the monitor only.
    logic [15:0] log_addr [1024];
    logic [1:0]  log_data [1024];
    int          n_wr = 0;

    always @(negedge clk_in) begin
        if (wr_en && n_wr < 1024) begin
            log_addr[n_wr] = wr_addr;
            log_data[n_wr] = wr_data;
            n_wr++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Holds byte_valid high until the byte transfers; returns cycles spent stalled.
    task automatic send_byte(input logic [7:0] b, input string tag, output int stalls);
        stalls     = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && stalls < 50) begin
            stalls++;
            step();
        end
        if (!byte_ready) begin
            check({tag, "_ready_wait"}, 32'(byte_ready), 32'd1);
        end else begin
            step();
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int base;
        int st;
        int stall_bad;
        int cell_bad;
        int exp_st;
        string p;
        p         = $sformatf("v%0d", idx);
        base      = n_wr;
        stall_bad = 0;
        cell_bad  = 0;

        for (int i = 0; i < v.n_lead; i++) begin
            send_byte(v.lead[8*i +: 8], p, st);
            if (st != 0) stall_bad++;
        end
        send_byte(8'hA5, p, st);
        if (st != 0) stall_bad++;
        send_byte(v.sx, p, st);
        if (st != 0) stall_bad++;
        send_byte(v.sy, p, st);
        if (st != 0) stall_bad++;
        for (int k = 0; k < 4; k++) begin
            send_byte(v.payload[8*k +: 8], p, st);
            exp_st = (k == 0) ? 0 : 3;
            if (st != exp_st) stall_bad++;
        end
        if (v.gap > 0) begin
            byte_valid = 1'b0;
            repeat (v.gap) step();
        end
        send_byte(v.csum, p, st);
        exp_st = (v.gap >= 3) ? 0 : 3 - v.gap;
        if (st != exp_st) stall_bad++;
        byte_valid = 1'b0;

        // Result pulse appears in the cycle right after the checksum transfer.
        check({p, "_done_pulse"}, 32'(load_done), 32'(v.exp_done));
        check({p, "_error_pulse"}, 32'(load_error), 32'(!v.exp_done));
        step();
        check({p, "_pulse_width"}, 32'({load_done, load_error}), 32'd0);
        step();
        check({p, "_error_code"}, 32'(error_code), 32'(v.exp_err));
        check({p, "_map_valid"}, 32'(map_valid), 32'(v.exp_done));
        check({p, "_start_x"}, 32'(start_x), 32'(v.sx));
        check({p, "_start_y"}, 32'(start_y), 32'(v.sy));
        check({p, "_busy"}, 32'(busy), 32'd0);
        check({p, "_write_count"}, 32'(n_wr - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (log_addr[base + i] !== 16'(i) || log_data[base + i] !== v.exp_cells[2*i +: 2])
                cell_bad++;
        end
        check({p, "_bad_cells"}, 32'(cell_bad), 32'd0);
        check({p, "_bad_stalls"}, 32'(stall_bad), 32'd0);
    endtask

    initial begin
        int st;
        int k_err;
        int k_last_wr;
        int base;

        // 03^01^E4^1B^00^FF = 02; cells 0,1,2,3 3,2,1,0 0,0,0,0 3,3,3,3
        vecs[0] = '{0, 16'h0000, 8'h03, 8'h01, 32'hFF001BE4, 8'h02, 0, 1'b1, 2'd0, 32'hFF001BE4};
        vecs[1] = '{0, 16'h0000, 8'h03, 8'h01, 32'hFF001BE4, 8'h00, 0, 1'b0, 2'd1, 32'hFF001BE4};
        // start_x out of range with a correct checksum (08^01 = 09)
        vecs[2] = '{0, 16'h0000, 8'h08, 8'h01, 32'hFF001BE4, 8'h09, 0, 1'b0, 2'd2, 32'hFF001BE4};
        // leading garbage 00 then 12, discarded in IDLE
        vecs[3] = '{2, 16'h1200, 8'h03, 8'h01, 32'hFF001BE4, 8'h02, 0, 1'b1, 2'd0, 32'hFF001BE4};
        // sync value as payload and checksum data; checksum taken from the CHECK state
        vecs[4] = '{0, 16'h0000, 8'h00, 8'h00, 32'h000000A5, 8'hA5, 5, 1'b1, 2'd0, 32'h000000A5};
        // start_y == HEIGHT is out of bounds
        vecs[5] = '{0, 16'h0000, 8'h07, 8'h02, 32'h00000000, 8'h05, 0, 1'b0, 2'd2, 32'h00000000};
        // largest legal start cell; checksum arrives one stall cycle after the gap
        vecs[6] = '{0, 16'h0000, 8'h07, 8'h01, 32'h00000000, 8'h06, 2, 1'b1, 2'd0, 32'h00000000};

        rst_in     = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (2) step();
        check("rst_byte_ready", 32'(byte_ready), 32'd1);
        check("rst_wr", 32'({wr_en, wr_data, wr_addr}), 32'd0);
        check("rst_flags", 32'({busy, load_done, load_error, map_valid}), 32'd0);
        check("rst_error_code", 32'(error_code), 32'd0);
        check("rst_start", 32'({start_x, start_y}), 32'd0);
        rst_in = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
            repeat (2) step();
        end

        // Timeout: frame stops after the second payload byte.
        base = n_wr;
        send_byte(8'hA5, "to", st);
        send_byte(8'h03, "to", st);
        send_byte(8'h01, "to", st);
        send_byte(8'hE4, "to", st);
        send_byte(8'h1B, "to", st);
        byte_valid = 1'b0;
        k_err     = -1;
        k_last_wr = -1;
        for (int k = 0; k < 100; k++) begin
            if (wr_en) k_last_wr = k;
            if (load_error) begin
                k_err = k;
                break;
            end
            step();
        end
        check("to_seen", 32'(k_err >= 0), 32'd1);
        check("to_idle_cycles", 32'(k_err - k_last_wr - 1), 32'(TO));
        check("to_error_code", 32'(error_code), 32'd3);
        check("to_busy", 32'(busy), 32'd0);
        check("to_map_valid", 32'(map_valid), 32'd0);
        check("to_write_count", 32'(n_wr - base), 32'd8);
        step();
        check("to_pulse_width", 32'(load_error), 32'd0);
        repeat (2) step();

        // Reset during the third cell write of a payload byte.
        send_byte(8'hA5, "rs", st);
        send_byte(8'h03, "rs", st);
        send_byte(8'h01, "rs", st);
        send_byte(8'hE4, "rs", st);
        byte_valid = 1'b0;
        step();
        step();
        check("rs_third_write", 32'({wr_en, wr_addr}), 32'h10002);
        rst_in = 1'b1;
        step();
        check("rs_wr_en", 32'(wr_en), 32'd0);
        check("rs_idle", 32'({busy, byte_ready}), 32'b01);
        check("rs_wr_addr", 32'(wr_addr), 32'd0);
        rst_in = 1'b0;
        step();
        run_vec(vecs[0], 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
